// File: rtl/tilt_motion_ctrl_if.sv
// Sample handshake between the accelerometer front end and tilt_motion_ctrl.
//
// Handshake: a sample transfers on a rising slowclk edge where sample_valid
// and sample_ready are both high. The master holds accel_data stable while
// sample_valid is high. sample_ready may drop at any time without a transfer.
// A sample offered while sample_ready is low is simply not taken.
interface tilt_motion_ctrl_if #(
    parameter int NUM_AXES = 2,
    parameter int DATA_W   = 16
);
    logic                         sample_valid;
    logic                         sample_ready;
    logic [NUM_AXES*DATA_W-1:0]   accel_data;

    modport master (
        output sample_valid,
        output accel_data,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  accel_data,
        output sample_ready
    );
endinterface

// File: rtl/tilt_motion_ctrl.sv
// Accelerometer-to-position controller. Each axis runs a power-of-two
// moving-average filter, maps the filtered tilt to a capped speed outside a
// dead zone, and moves a clamped position once per accepted sample.
// state_dbg exposes the controller state for checkers.
module tilt_motion_ctrl #(
    parameter int NUM_AXES   = 2,
    parameter int DATA_W     = 16,
    parameter int POS_W      = 16,
    parameter int AVG_LOG2   = 2,
    parameter int DEADZONE   = 128,
    parameter int TILT_SHIFT = 7,
    parameter int MAX_SPEED  = 4
) (
    input  logic                        slowclk,
    input  logic                        reset_n,
    tilt_motion_ctrl_if.slave           sif,
    input  logic [NUM_AXES-1:0]         invert,
    input  logic [NUM_AXES*POS_W-1:0]   pos_init,
    input  logic [NUM_AXES*POS_W-1:0]   pos_max,
    input  logic                        recenter,
    input  logic                        freeze,
    output logic [NUM_AXES*POS_W-1:0]   pos,
    output logic                        pos_valid,
    output logic                        pos_upd,
    output logic [NUM_AXES-1:0]         moving,
    output logic [NUM_AXES-1:0]         at_min,
    output logic [NUM_AXES-1:0]         at_max,
    output logic [1:0]                  state_dbg
);
    localparam int D  = 1 << AVG_LOG2;
    localparam int AW = DATA_W + AVG_LOG2;      // accumulator width
    localparam int MW = DATA_W + 1;             // magnitude width, holds 2^(DATA_W-1)
    localparam int SW = $clog2(MAX_SPEED + 1);  // speed width
    localparam int FW = AVG_LOG2 + 1;           // fill count 0..D
    localparam int NW = POS_W + 2;              // signed next-position width

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_FILTER = 2'd2,
        ST_STEP   = 2'd3
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   win_q   [NUM_AXES][D];   // index 0 newest, D-1 oldest
    logic signed [AW-1:0] acc_q  [NUM_AXES];
    logic [FW-1:0]       fill_q;
    logic [SW-1:0]       speed_q [NUM_AXES];
    logic [NUM_AXES-1:0] dir_q;                   // 1 = move toward 0

    logic [DATA_W-1:0]   sample_w [NUM_AXES];
    logic [AW-1:0]       acc_nxt  [NUM_AXES];
    logic [SW-1:0]       spd_w    [NUM_AXES];
    logic [NUM_AXES-1:0] neg_w;
    logic [NUM_AXES*POS_W-1:0] step_pos, init_pos;
    logic [NUM_AXES-1:0] step_min, step_max, init_min, init_max;

    assign sif.sample_ready = (state_q == ST_IDLE) && !recenter;
    assign state_dbg        = state_q;

    // Per-axis datapath: window update, average, speed/direction, clamped next position.
    always_comb begin
        logic [DATA_W-1:0] avg;
        logic [MW-1:0]     avg_ext, mag, excess, quot;
        logic [NW-1:0]     cur, delta, nxt;
        logic [POS_W-1:0]  lim, clamped, ini;
        avg = '0; avg_ext = '0; mag = '0; excess = '0; quot = '0;
        cur = '0; delta = '0; nxt = '0; lim = '0; clamped = '0; ini = '0;
        step_pos = '0; init_pos = '0;
        step_min = '0; step_max = '0; init_min = '0; init_max = '0;
        neg_w = '0;
        for (int k = 0; k < NUM_AXES; k++) begin
            sample_w[k] = sif.accel_data[k*DATA_W +: DATA_W];
            acc_nxt[k]  = acc_q[k]
                        + {{AVG_LOG2{sample_w[k][DATA_W-1]}}, sample_w[k]}
                        - {{AVG_LOG2{win_q[k][D-1][DATA_W-1]}}, win_q[k][D-1]};

            // Dropping the low AVG_LOG2 bits is the arithmetic shift of the sum.
            avg     = acc_q[k][AW-1:AVG_LOG2];
            avg_ext = {avg[DATA_W-1], avg};
            mag     = avg[DATA_W-1] ? (~avg_ext + MW'(1)) : avg_ext;
            excess  = mag - MW'(DEADZONE);
            quot    = (excess >> TILT_SHIFT) + MW'(1);
            if (mag <= MW'(DEADZONE))
                spd_w[k] = '0;
            else if (quot > MW'(MAX_SPEED))
                spd_w[k] = SW'(MAX_SPEED);
            else
                spd_w[k] = quot[SW-1:0];
            neg_w[k] = avg[DATA_W-1] ^ invert[k];

            lim   = pos_max[k*POS_W +: POS_W];
            cur   = {2'b00, pos[k*POS_W +: POS_W]};
            delta = {{(NW-SW){1'b0}}, speed_q[k]};
            if (freeze)
                nxt = cur;
            else if (dir_q[k])
                nxt = cur - delta;
            else
                nxt = cur + delta;
            if (nxt[NW-1])
                clamped = '0;
            else if (nxt > {2'b00, lim})
                clamped = lim;
            else
                clamped = nxt[POS_W-1:0];
            step_pos[k*POS_W +: POS_W] = clamped;
            step_min[k] = (clamped == '0);
            step_max[k] = (clamped == lim);

            ini = (pos_init[k*POS_W +: POS_W] > lim) ? lim : pos_init[k*POS_W +: POS_W];
            init_pos[k*POS_W +: POS_W] = ini;
            init_min[k] = (ini == '0);
            init_max[k] = (ini == lim);
        end
    end

    // Controller FSM with registered outputs; recenter overrides every state.
    always_ff @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT;
            pos       <= '0;
            pos_valid <= 1'b0;
            pos_upd   <= 1'b0;
            moving    <= '0;
            at_min    <= '0;
            at_max    <= '0;
            fill_q    <= '0;
            dir_q     <= '0;
            for (int k = 0; k < NUM_AXES; k++) begin
                acc_q[k]   <= '0;
                speed_q[k] <= '0;
                for (int j = 0; j < D; j++) win_q[k][j] <= '0;
            end
        end else begin
            pos_upd <= 1'b0;
            if (recenter || state_q == ST_INIT) begin
                pos       <= init_pos;
                pos_valid <= 1'b1;
                at_min    <= init_min;
                at_max    <= init_max;
                state_q   <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sif.sample_valid) begin
                            for (int k = 0; k < NUM_AXES; k++) begin
                                for (int j = D - 1; j > 0; j--) win_q[k][j] <= win_q[k][j-1];
                                win_q[k][0] <= sample_w[k];
                                acc_q[k]    <= acc_nxt[k];
                            end
                            if (fill_q < FW'(D)) fill_q <= fill_q + FW'(1);
                            state_q <= ST_FILTER;
                        end
                    end
                    ST_FILTER: begin
                        if (fill_q < FW'(D)) begin
                            state_q <= ST_IDLE;
                        end else begin
                            for (int k = 0; k < NUM_AXES; k++) speed_q[k] <= spd_w[k];
                            dir_q   <= neg_w;
                            state_q <= ST_STEP;
                        end
                    end
                    ST_STEP: begin
                        pos <= step_pos;
                        for (int k = 0; k < NUM_AXES; k++)
                            moving[k] <= (speed_q[k] != '0) && !freeze;
                        at_min  <= step_min;
                        at_max  <= step_max;
                        pos_upd <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tilt_motion_ctrl.sv
// Bench for tilt_motion_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_tilt_motion_ctrl;
    localparam int NA = 2;
    localparam int DW = 16;
    localparam int PW = 16;

    logic slowclk = 1'b0;
    logic reset_n = 1'b0;
    logic [NA-1:0]    invert = '0;
    logic [NA*PW-1:0] pos_init = '0;
    logic [NA*PW-1:0] pos_max = '0;
    logic             recenter = 1'b0;
    logic             freeze = 1'b0;
    logic [NA*PW-1:0] pos;
    logic             pos_valid, pos_upd;
    logic [NA-1:0]    moving, at_min, at_max;
    logic [1:0]       state_dbg;

    tilt_motion_ctrl_if #(.NUM_AXES(NA), .DATA_W(DW)) sif ();

    tilt_motion_ctrl dut (
        .slowclk   (slowclk),
        .reset_n   (reset_n),
        .sif       (sif),
        .invert    (invert),
        .pos_init  (pos_init),
        .pos_max   (pos_max),
        .recenter  (recenter),
        .freeze    (freeze),
        .pos       (pos),
        .pos_valid (pos_valid),
        .pos_upd   (pos_upd),
        .moving    (moving),
        .at_min    (at_min),
        .at_max    (at_max),
        .state_dbg (state_dbg)
    );

    // clock
    always #5 slowclk = ~slowclk;

    int n_total = 0;
    int n_pass  = 0;
    int upd_cnt = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_pos [NA];
    bit m_valid, m_upd;
    bit [NA-1:0] m_moving, m_min, m_max;
    bit m_init_pend, pend_f, pend_s;
    int m_spd [NA];
    bit m_neg [NA];
    int hist [NA][$];

    function automatic int lim_of(input int k);
        return int'(pos_max[k*PW +: PW]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NA; k++) begin
            m_pos[k] = 0; m_spd[k] = 0; m_neg[k] = 0;
            hist[k].delete();
        end
        m_valid = 0; m_upd = 0; m_moving = '0; m_min = '0; m_max = '0;
        m_init_pend = 1; pend_f = 0; pend_s = 0;
    endtask

    task automatic model_edge();
        m_upd = 0;
        if (m_init_pend || recenter) begin
            for (int k = 0; k < NA; k++) begin
                int p;
                p = int'(pos_init[k*PW +: PW]);
                if (p > lim_of(k)) p = lim_of(k);
                m_pos[k] = p;
                m_min[k] = (p == 0);
                m_max[k] = (p == lim_of(k));
            end
            m_valid = 1; m_init_pend = 0; pend_f = 0; pend_s = 0;
        end else if (pend_s) begin
            for (int k = 0; k < NA; k++) begin
                int nxt;
                nxt = freeze ? m_pos[k] : (m_neg[k] ? m_pos[k] - m_spd[k] : m_pos[k] + m_spd[k]);
                if (nxt < 0) nxt = 0;
                if (nxt > lim_of(k)) nxt = lim_of(k);
                m_pos[k]    = nxt;
                m_moving[k] = (m_spd[k] != 0) && !freeze;
                m_min[k]    = (nxt == 0);
                m_max[k]    = (nxt == lim_of(k));
            end
            m_upd = 1; pend_s = 0;
        end else if (pend_f) begin
            pend_f = 0;
            if (hist[0].size() == 4) begin
                for (int k = 0; k < NA; k++) begin
                    int sum, avg, mag, s;
                    sum = 0;
                    foreach (hist[k][i]) sum += hist[k][i];
                    avg = sum >>> 2;
                    mag = (avg < 0) ? -avg : avg;
                    if (mag <= 128) s = 0;
                    else begin
                        s = ((mag - 128) >> 7) + 1;
                        if (s > 4) s = 4;
                    end
                    m_spd[k] = s;
                    m_neg[k] = (avg < 0) ^ invert[k];
                end
                pend_s = 1;
            end
        end else if (sif.sample_valid) begin
            for (int k = 0; k < NA; k++) begin
                hist[k].push_back(int'($signed(sif.accel_data[k*DW +: DW])));
                if (hist[k].size() > 4) void'(hist[k].pop_front());
            end
            pend_f = 1;
        end
    endtask

    function automatic bit exp_ready();
        return reset_n && !m_init_pend && !pend_f && !pend_s && !recenter;
    endfunction

    // model advances on every active edge and on async reset
    always @(posedge slowclk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_edge();
    end

    // compare DUT outputs with the model shortly after each edge
    always @(posedge slowclk) begin
        #2;
        if (chk_en) begin
            if (pos_upd) upd_cnt++;
            check("pos_x",     pos[15:0],  m_pos[0]);
            check("pos_y",     pos[31:16], m_pos[1]);
            check("pos_valid", pos_valid,  m_valid);
            check("pos_upd",   pos_upd,    m_upd);
            check("moving",    moving,     m_moving);
            check("at_min",    at_min,     m_min);
            check("at_max",    at_max,     m_max);
            check("ready",     sif.sample_ready, exp_ready());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_data(input int x, input int y);
        logic [15:0] xs, ys;
        xs = x[15:0];
        ys = y[15:0];
        sif.accel_data = {ys, xs};
    endtask

    task automatic send(input int x, input int y);
        int n;
        n = 0;
        while (!exp_ready() && n < 20) begin
            @(negedge slowclk);
            n++;
        end
        if (n >= 20) fail_now("send_wait");
        sif.sample_valid = 1'b1;
        set_data(x, y);
        @(negedge slowclk);
        sif.sample_valid = 1'b0;
    endtask

    task automatic send4(input int x, input int y);
        for (int i = 0; i < 4; i++) send(x, y);
        repeat (4) @(negedge slowclk);
    endtask

    task automatic settle();
        repeat (4) @(negedge slowclk);
    endtask

    task automatic pulse_recenter();
        recenter = 1'b1;
        @(negedge slowclk);
        recenter = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

    initial begin
        int u0;
        sif.sample_valid = 1'b0;
        sif.accel_data   = '0;
        pos_init = {16'd240, 16'd300};
        pos_max  = {16'd440, 16'd600};
        repeat (2) @(negedge slowclk);
        // reset state
        check("rst_pos",   pos, 0);
        check("rst_valid", pos_valid, 0);
        check("rst_ready", sif.sample_ready, 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(negedge slowclk);
        check("init_x", pos[15:0], 300);
        check("init_y", pos[31:16], 240);
        check("init_valid", pos_valid, 1);
        check("init_ready", sif.sample_ready, 1);
        check("init_upd", pos_upd, 0);

        // warm-up then first step
        u0 = upd_cnt;
        for (int i = 0; i < 3; i++) send(1000, 0);
        settle();
        check("warmup_upd", upd_cnt - u0, 0);
        send(1000, 0);
        settle();
        check("step_x", pos[15:0], 304);
        check("step_upd", upd_cnt - u0, 1);
        check("step_moving", moving, 2'b01);

        // dead zone: final window averages to 0 and -128
        u0 = upd_cnt;
        send(100, -128); send(-100, -128); send(100, -128); send(-100, -128);
        settle();
        check("dz_x", pos[15:0], 313);
        check("dz_y", pos[31:16], 240);
        check("dz_moving", moving, 2'b00);
        check("dz_upd", upd_cnt - u0, 4);

        // clamp at pos_max
        pos_init = {16'd240, 16'd598};
        pulse_recenter();
        check("rc_x", pos[15:0], 598);
        send4(1000, 0);
        check("clamp_max_x", pos[15:0], 600);
        check("clamp_at_max", at_max, 2'b01);
        // clamp at 0
        pos_init = {16'd240, 16'd2};
        pulse_recenter();
        send4(-1000, 0);
        check("clamp_min_x", pos[15:0], 0);
        check("clamp_at_min", at_min, 2'b01);
        // lowered pos_max
        pos_init = {16'd240, 16'd598};
        pulse_recenter();
        send4(1000, 0);
        pos_max = {16'd440, 16'd500};
        send4(0, 0);
        check("lowmax_x", pos[15:0], 500);
        check("lowmax_at_max", at_max, 2'b01);

        // inversion and freeze
        pos_max  = {16'd440, 16'd600};
        pos_init = {16'd240, 16'd300};
        pulse_recenter();
        invert = 2'b10;
        freeze = 1'b1;
        send4(0, 384);
        check("frz_y", pos[31:16], 240);
        check("frz_moving", moving, 2'b00);
        freeze = 1'b0;
        send(0, 384);
        settle();
        check("inv_y", pos[31:16], 237);
        check("inv_x", pos[15:0], 300);
        check("inv_moving", moving, 2'b10);
        invert = 2'b00;

        // recenter during FILTER with a sample offered
        u0 = upd_cnt;
        send(500, 0);
        recenter = 1'b1;
        sif.sample_valid = 1'b1;
        set_data(-1000, 0);
        @(negedge slowclk);
        recenter = 1'b0;
        sif.sample_valid = 1'b0;
        check("abort_x", pos[15:0], 300);
        check("abort_y", pos[31:16], 240);
        settle();
        check("abort_upd", upd_cnt - u0, 0);

        // async reset during STEP
        send(1000, 0);
        @(negedge slowclk);
        reset_n = 1'b0;
        #1;
        check("arst_pos", pos, 0);
        check("arst_valid", pos_valid, 0);
        @(negedge slowclk);
        reset_n = 1'b1;
        @(negedge slowclk);
        u0 = upd_cnt;
        for (int i = 0; i < 3; i++) send(1000, 0);
        settle();
        check("rewarm_upd", upd_cnt - u0, 0);
        send(1000, 0);
        settle();
        check("rewarm_step_upd", upd_cnt - u0, 1);
        check("rewarm_x", pos[15:0], 304);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int x, y;
            x = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? -32768 : 32767)
                                            : int'($urandom_range(0, 2400)) - 1200;
            y = int'($urandom_range(0, 2400)) - 1200;
            sif.sample_valid = 1'($urandom_range(0, 1));
            set_data(x, y);
            recenter = ($urandom_range(0, 39) == 0);
            freeze   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) invert = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0)
                pos_max = {16'($urandom_range(0, 700)), 16'($urandom_range(0, 700))};
            if ($urandom_range(0, 99) == 0)
                pos_init = {16'($urandom_range(0, 800)), 16'($urandom_range(0, 800))};
            reset_n = ($urandom_range(0, 299) != 0);
            @(negedge slowclk);
        end
        sif.sample_valid = 1'b0;
        recenter = 1'b0;
        reset_n  = 1'b1;
        settle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/tilt_motion_ctrl.md
Name: tilt_motion_ctrl

Overview:
Parametrised accelerometer-to-position controller for N axes, running on the slowed accelerometer clock.
Each axis gets a power-of-two moving-average filter, a configurable dead zone and proportional speed quantisation with a cap. Positions are clamped to runtime bounds, and the block supports per-axis inversion, freeze and recentre.
Its outputs drive sprite coordinates (spaceship, cursors) in the top level, replacing fixed-threshold, fixed-step movement logic.

Parameters:
NUM_AXES, 2, number of independent tilt axes
DATA_W, 16, accelerometer sample width, signed two's complement
POS_W, 16, position width, unsigned
AVG_LOG2, 2, log2 of moving-average window depth (window = 4)
DEADZONE, 128, |avg| at or below this value gives zero speed
TILT_SHIFT, 7, right shift applied to (|avg| - DEADZONE) to form speed
MAX_SPEED, 4, speed cap in position units per step

Ports:
slowclk  in  1  block clock
reset_n  in  1  asynchronous, active-low reset
sample_valid  in  1  accel_data valid this cycle
sample_ready  out  1  block accepts sample this cycle
accel_data  in  NUM_AXES*DATA_W  packed samples; axis k at [k*DATA_W +: DATA_W]
invert  in  NUM_AXES  per-axis direction inversion
pos_init  in  NUM_AXES*POS_W  recentre/initial position
pos_max  in  NUM_AXES*POS_W  per-axis upper bound; lower bound is 0
recenter  in  1  load pos_init
freeze  in  1  suppress position change; filter keeps running
pos  out  NUM_AXES*POS_W  current position
pos_valid  out  1  position has been initialised
pos_upd  out  1  one-cycle pulse when a STEP commits
moving  out  NUM_AXES  axis had nonzero speed in the last STEP
at_min  out  NUM_AXES  axis position == 0
at_max  out  NUM_AXES  axis position == pos_max

Behaviour:
- Reset (async, reset_n=0):
  - State goes to INIT.
  - pos=0; pos_valid, pos_upd, moving, at_min, at_max = 0.
  - Windows, accumulators and fill count cleared.
- FSM states: INIT, IDLE, FILTER, STEP.
- sample_ready = (state==IDLE) & ~recenter, combinational.
- INIT: on the first edge, pos <= min(pos_init, pos_max) per axis; pos_valid <= 1; go to IDLE.
- IDLE: on sample_valid & sample_ready, for each axis:
  - Shift the sample into a window of depth D=2^AVG_LOG2.
  - acc <= acc + new - oldest. acc is signed, DATA_W+AVG_LOG2 bits.
  - fill <= min(fill+1, D).
  - Go to FILTER.
- Samples offered when sample_ready=0 are dropped with no side effects.
- FILTER: avg = acc >>> AVG_LOG2 (arithmetic shift).
  - If fill < D (warm-up): return to IDLE; no STEP, no pos_upd.
  - Otherwise compute speed and direction per axis, then go to STEP:
    - mag = |avg| in DATA_W+1 bits, so -2^(DATA_W-1) is handled.
    - speed = 0 if mag <= DEADZONE, else min(((mag-DEADZONE) >> TILT_SHIFT) + 1, MAX_SPEED).
    - dir = sign(avg) XOR invert[k].
    - speed and dir are registered.
- STEP:
  - Compute next = pos ± speed in POS_W+2 signed bits, then clamp to [0, pos_max].
  - If freeze=1, next = pos, but the clamp still applies.
  - A pos_max lowered below pos is clamped on the next STEP even when speed is 0.
  - Register pos, moving = (speed != 0) & ~freeze, at_min and at_max.
  - pos_upd = 1 for exactly one cycle.
  - Return to IDLE.
- Latency: a sample accepted at edge t produces pos/pos_upd visible after edge t+2 (IDLE to FILTER to STEP to IDLE). Throughput is one sample per 3 cycles.
- recenter: highest priority after reset, in any state.
  - Next edge: pos <= min(pos_init, pos_max); pos_valid <= 1; go to IDLE.
  - An in-flight FILTER or STEP is aborted: no pos_upd.
  - Filter windows are kept.
- at_min and at_max are also updated on INIT and recenter.
- Reset mid-operation: immediate, per the reset values above; warm-up restarts.

Test Plan:
1. reset_n pulse with pos_init=(300,240), pos_max=(600,440) -> pos=(0,0) during reset; after the first edge pos=(300,240), pos_valid=1, sample_ready=1, pos_upd=0.
2. Four samples x=+1000, y=0 -> first three give no pos_upd. After the fourth: avg 1000, speed min(((872>>7)+1),4)=4, x=304 two edges after acceptance, pos_upd single pulse, moving=(1,0).
3. Samples x alternating +100/-100, y=-128 -> speed 0, pos unchanged, pos_upd pulses, moving=0.
4. Clamp: x=598 with avg +1000 -> x=600, at_max[0]=1. x=2 with avg -1000 -> x=0, at_min[0]=1. pos_max[0] lowered to 500 with avg 0 -> x=500 after the next STEP.
5. invert[1]=1, four samples y=+384 -> speed ((256>>7)+1)=3, y 240->237. Same with freeze=1 -> y stays 240, moving=0.
6. sample_valid and recenter asserted together in FILTER -> sample dropped, pos=pos_init next edge, no pos_upd. Async reset_n low mid-STEP -> pos=0 immediately, next four samples re-enter warm-up.
